// File: rtl/riscv_pkg.sv
// Shared types and constants for the load/store unit and its lane-alignment helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane handling: store replication and byte enables, misalignment detect,
// and load lane extraction with sign/zero extension.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_wdata_rep,
    output logic [3:0]  st_be,
    output logic        st_misaligned,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata_rep  = st_wdata;
        st_be         = BE_WORD;
        st_misaligned = 1'b0;
        case (st_size)
            MEM_BYTE: begin
                st_be        = BE_BYTE << st_offset;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            MEM_HALF: begin
                st_be         = BE_HALF << st_offset;
                st_wdata_rep  = {2{st_wdata[15:0]}};
                st_misaligned = st_offset[0];
            end
            default: st_misaligned = |st_offset;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            MEM_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            MEM_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default:  ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns control-FSM read/write strobes into a req/gnt/rvalid bus
// transaction, stalling the control FSM until the access completes or aborts.
//
// state | meaning
// IDLE  | waiting for ren_i/wen_i; misaligned requests skip straight to DONE
// REQ   | bus_req_o held with stable fields until bus_gnt_i
// WAIT  | request accepted, waiting for bus_rvalid_i
// DONE  | one-cycle completion pulse, stall released
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        timeout_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    lsu_state_t  state_q, state_n;
    logic [31:0] cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic [31:0] st_wdata_rep;
    logic [3:0]  st_be;
    logic        st_misaligned;
    logic [31:0] ld_data;

    logic        access;
    logic        to_hit;
    logic        fin_mis;
    logic        fin_to;
    logic        ld_fire;

    riscv_lsu_align u_align (
        .st_offset     (addr_i[1:0]),
        .st_size       (size_i),
        .st_wdata      (wdata_i),
        .st_wdata_rep  (st_wdata_rep),
        .st_be         (st_be),
        .st_misaligned (st_misaligned),
        .ld_offset     (off_q),
        .ld_size       (size_q),
        .ld_unsigned   (uns_q),
        .ld_word       (bus_rdata_i),
        .ld_data       (ld_data)
    );

    assign access = ren_i | wen_i;
    // Budget counts every REQ+WAIT cycle; >= keeps it firing if gnt landed on the limit.
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TIMEOUT_CYCLES - 1);

    always_comb begin
        state_n = state_q;
        stall_o = 1'b0;
        fin_mis = 1'b0;
        fin_to  = 1'b0;
        ld_fire = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (access) begin
                    stall_o = 1'b1;
                    if (st_misaligned) begin
                        state_n = LSU_DONE;
                        fin_mis = 1'b1;
                    end else begin
                        state_n = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                stall_o = 1'b1;
                if (bus_gnt_i) begin
                    state_n = LSU_WAIT;
                end else if (to_hit) begin
                    state_n = LSU_DONE;
                    fin_to  = 1'b1;
                end
            end
            LSU_WAIT: begin
                stall_o = 1'b1;
                if (bus_rvalid_i) begin
                    state_n = LSU_DONE;
                    ld_fire = ~bus_we_o;
                end else if (to_hit) begin
                    state_n = LSU_DONE;
                    fin_to  = 1'b1;
                end
            end
            default: state_n = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rdata_o      <= '0;
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            timeout_o    <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_be_o     <= '0;
        end else begin
            state_q      <= state_n;
            done_o       <= (state_n == LSU_DONE);
            misaligned_o <= fin_mis;
            timeout_o    <= fin_to;
            bus_req_o    <= (state_n == LSU_REQ);
            if (state_q == LSU_IDLE && state_n == LSU_REQ) begin
                cnt_q       <= '0;
                off_q       <= addr_i[1:0];
                size_q      <= size_i;
                uns_q       <= unsigned_i;
                bus_we_o    <= wen_i;
                bus_addr_o  <= {addr_i[31:2], 2'b00};
                bus_wdata_o <= st_wdata_rep;
                bus_be_o    <= st_be;
            end else if (state_q == LSU_REQ || state_q == LSU_WAIT) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (ld_fire) begin
                rdata_o <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu: loads, stores, misalignment,
// back-to-back, bus wait states, timeout and mid-transaction reset.
module tb_riscv_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ren = 1'b0, wen = 1'b0, uns = 1'b0;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic [1:0]  size = 2'b10;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;

    logic        stall, done, mis, tmo, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        ren_t = 1'b0, wen_t = 1'b0, gnt_t = 1'b0;
    logic        stall_t, done_t, mis_t, tmo_t, bus_req_t, bus_we_t;
    logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;
    logic [3:0]  bus_be_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    riscv_lsu dut (
        .clock(clock), .reset(reset), .ren_i(ren), .wen_i(wen), .addr_i(addr),
        .wdata_i(wdata), .size_i(size), .unsigned_i(uns), .stall_o(stall),
        .done_o(done), .rdata_o(rdata), .misaligned_o(mis), .timeout_o(tmo),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_be_o(bus_be), .bus_gnt_i(bus_gnt),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
    );

    riscv_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clock(clock), .reset(reset), .ren_i(ren_t), .wen_i(wen_t), .addr_i(addr),
        .wdata_i(wdata), .size_i(size), .unsigned_i(uns), .stall_o(stall_t),
        .done_o(done_t), .rdata_o(rdata_t), .misaligned_o(mis_t), .timeout_o(tmo_t),
        .bus_req_o(bus_req_t), .bus_we_o(bus_we_t), .bus_addr_o(bus_addr_t),
        .bus_wdata_o(bus_wdata_t), .bus_be_o(bus_be_t), .bus_gnt_i(gnt_t),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
    );

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Bus responder: issues a request in cycle 0, then grants/acks after the given
    // number of wait cycles. Returns the cycle of done_o (-1 if never seen).
    task automatic run_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input logic u, input int gd, input int rd,
                              input logic [31:0] rword, output int done_cyc, output int req_cyc,
                              output logic [31:0] c_addr, output logic [31:0] c_wdata,
                              output logic [3:0] c_be, output logic c_we);
        int gcnt, rcnt;
        logic in_wait;
        gcnt = 0; rcnt = 0; in_wait = 1'b0;
        done_cyc = -1; req_cyc = 0;
        c_addr = 'x; c_wdata = 'x; c_be = 'x; c_we = 1'bx;
        ren = ~we; wen = we; addr = a; wdata = wd; size = sz; uns = u;
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            if (bus_req) begin
                req_cyc++;
                c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be; c_we = bus_we;
                if (gcnt == gd) begin
                    bus_gnt = 1'b1;
                    in_wait = 1'b1;
                end else gcnt++;
            end else if (in_wait) begin
                if (rcnt == rd) begin
                    bus_rvalid = 1'b1;
                    bus_rdata = rword;
                    in_wait = 1'b0;
                end else rcnt++;
            end
            tick();
        end
        ren = 1'b0; wen = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        vectors++; if (bus_req !== 1'b0 || done !== 1'b0 || mis !== 1'b0 || tmo !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags req=%b done=%b mis=%b tmo=%b expected 0000", bus_req, done, mis, tmo); end
        vectors++; if (rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_be !== 4'h0 || bus_we !== 1'b0) begin
            miscompares++; $display("FAIL reset_regs rdata=%h addr=%h wdata=%h be=%b we=%b expected zeros", rdata, bus_addr, bus_wdata, bus_be, bus_we); end
        vectors++; if (stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_stall_idle got %b expected 0", stall); end
        ren = 1'b1; #1;
        vectors++; if (stall !== 1'b1) begin
            miscompares++; $display("FAIL reset_stall_req got %b expected 1", stall); end
        ren = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_word_load;
        int dc, rc; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        addr = 32'h100; size = 2'b10; ren = 1'b1; #1;
        vectors++; if (stall !== 1'b1) begin
            miscompares++; $display("FAIL word_load_stall0 got %b expected 1", stall); end
        run_access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 0, 32'hDEADBEEF, dc, rc, ca, cw, cb, cwe);
        vectors++; if (dc !== 3) begin
            miscompares++; $display("FAIL word_load_done_cycle got %0d expected 3", dc); end
        vectors++; if (rdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL word_load_rdata got %h expected deadbeef", rdata); end
        vectors++; if (cb !== 4'b1111 || cwe !== 1'b0 || ca !== 32'h100 || rc !== 1) begin
            miscompares++; $display("FAIL word_load_bus be=%b we=%b addr=%h reqcyc=%0d expected 1111 0 00000100 1", cb, cwe, ca, rc); end
        vectors++; if (stall !== 1'b0) begin
            miscompares++; $display("FAIL word_load_stall_done got %b expected 0", stall); end
        tick();
        vectors++; if (done !== 1'b0) begin
            miscompares++; $display("FAIL word_load_done_pulse got %b expected 0", done); end
    endtask

    task automatic test_sub_word_loads;
        int dc, rc; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        run_access(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 0, 0, 32'h80112233, dc, rc, ca, cw, cb, cwe);
        vectors++; if (rdata !== 32'hFFFFFF80 || dc !== 3) begin
            miscompares++; $display("FAIL signed_byte got %h cyc %0d expected ffffff80 cyc 3", rdata, dc); end
        tick();
        run_access(1'b0, 32'h101, 32'h0, 2'b00, 1'b1, 0, 0, 32'h80112233, dc, rc, ca, cw, cb, cwe);
        vectors++; if (rdata !== 32'h00000022) begin
            miscompares++; $display("FAIL unsigned_byte got %h expected 00000022", rdata); end
        tick();
        run_access(1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 0, 0, 32'h80112233, dc, rc, ca, cw, cb, cwe);
        vectors++; if (rdata !== 32'h00008011 || ca !== 32'h100) begin
            miscompares++; $display("FAIL unsigned_half got %h addr %h expected 00008011 addr 00000100", rdata, ca); end
        tick();
    endtask

    task automatic test_stores;
        int dc, rc; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        run_access(1'b1, 32'h201, 32'h000000AB, 2'b00, 1'b0, 0, 0, 32'h55555555, dc, rc, ca, cw, cb, cwe);
        vectors++; if (ca !== 32'h200 || cb !== 4'b0010 || cw !== 32'hABABABAB || cwe !== 1'b1) begin
            miscompares++; $display("FAIL byte_store addr=%h be=%b wdata=%h we=%b expected 00000200 0010 abababab 1", ca, cb, cw, cwe); end
        vectors++; if (rdata !== 32'h00008011 || dc !== 3) begin
            miscompares++; $display("FAIL store_keeps_rdata got %h cyc %0d expected 00008011 cyc 3", rdata, dc); end
        tick();
        run_access(1'b1, 32'h202, 32'h1234CDEF, 2'b01, 1'b0, 0, 0, 32'h0, dc, rc, ca, cw, cb, cwe);
        vectors++; if (ca !== 32'h200 || cb !== 4'b1100 || cw !== 32'hCDEFCDEF) begin
            miscompares++; $display("FAIL half_store addr=%h be=%b wdata=%h expected 00000200 1100 cdefcdef", ca, cb, cw); end
        tick();
        run_access(1'b1, 32'h204, 32'hCAFEF00D, 2'b11, 1'b0, 0, 0, 32'h0, dc, rc, ca, cw, cb, cwe);
        vectors++; if (ca !== 32'h204 || cb !== 4'b1111 || cw !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL word_store addr=%h be=%b wdata=%h expected 00000204 1111 cafef00d", ca, cb, cw); end
        tick();
    endtask

    task automatic test_misaligned;
        int dc, rc; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        ren = 1'b1; addr = 32'h101; size = 2'b01; uns = 1'b0; #1;
        vectors++; if (stall !== 1'b1 || bus_req !== 1'b0) begin
            miscompares++; $display("FAIL mis_cycle0 stall=%b req=%b expected 1 0", stall, bus_req); end
        tick();
        vectors++; if (done !== 1'b1 || mis !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0 || tmo !== 1'b0) begin
            miscompares++; $display("FAIL mis_cycle1 done=%b mis=%b stall=%b req=%b tmo=%b expected 1 1 0 0 0", done, mis, stall, bus_req, tmo); end
        ren = 1'b0;
        tick();
        vectors++; if (done !== 1'b0 || mis !== 1'b0 || bus_req !== 1'b0) begin
            miscompares++; $display("FAIL mis_cycle2 done=%b mis=%b req=%b expected 0 0 0", done, mis, bus_req); end
        run_access(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0, dc, rc, ca, cw, cb, cwe);
        vectors++; if (dc !== 1 || rc !== 0 || rdata !== 32'h00008011) begin
            miscompares++; $display("FAIL mis_word cyc=%0d reqcyc=%0d rdata=%h expected 1 0 00008011", dc, rc, rdata); end
        tick();
    endtask

    task automatic test_back_to_back;
        int dc, rc, c0, c1; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        run_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 0, 32'h11223344, dc, rc, ca, cw, cb, cwe);
        c0 = cyc;
        vectors++; if (rdata !== 32'h11223344) begin
            miscompares++; $display("FAIL b2b_first got %h expected 11223344", rdata); end
        tick();
        run_access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 0, 0, 32'hA5A58000, dc, rc, ca, cw, cb, cwe);
        c1 = cyc;
        vectors++; if (rdata !== 32'hFFFFA5A5 || (c1 - c0) !== 4) begin
            miscompares++; $display("FAIL b2b_second rdata=%h spacing=%0d expected ffffa5a5 4", rdata, c1 - c0); end
        tick();
    endtask

    task automatic test_wait_states;
        int dc, rc; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        run_access(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 3, 2, 32'h0BADF00D, dc, rc, ca, cw, cb, cwe);
        vectors++; if (dc !== 8 || rc !== 4 || rdata !== 32'h0BADF00D || tmo !== 1'b0) begin
            miscompares++; $display("FAIL wait_states cyc=%0d reqcyc=%0d rdata=%h tmo=%b expected 8 4 0badf00d 0", dc, rc, rdata, tmo); end
        tick();
    endtask

    task automatic test_timeout;
        int reqs;
        reqs = 0;
        ren_t = 1'b1; addr = 32'h300; size = 2'b10; gnt_t = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (bus_req_t === 1'b1 && done_t === 1'b0) reqs++;
            tick();
        end
        vectors++; if (reqs !== 4) begin
            miscompares++; $display("FAIL timeout_req_cycles got %0d expected 4", reqs); end
        vectors++; if (done_t !== 1'b1 || tmo_t !== 1'b1 || bus_req_t !== 1'b0 || stall_t !== 1'b0 || rdata_t !== 32'h0) begin
            miscompares++; $display("FAIL timeout_done done=%b tmo=%b req=%b stall=%b rdata=%h expected 1 1 0 0 0", done_t, tmo_t, bus_req_t, stall_t, rdata_t); end
        ren_t = 1'b0;
        tick();
        vectors++; if (done_t !== 1'b0 || tmo_t !== 1'b0 || bus_req_t !== 1'b0) begin
            miscompares++; $display("FAIL timeout_after done=%b tmo=%b req=%b expected 0 0 0", done_t, tmo_t, bus_req_t); end
    endtask

    task automatic test_mid_reset;
        ren = 1'b1; addr = 32'h104; size = 2'b10; uns = 1'b0;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; ren = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        vectors++; if (bus_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_abort req=%b done=%b stall=%b expected 0 0 0", bus_req, done, stall); end
        tick();
        bus_rvalid = 1'b0;
        vectors++; if (done !== 1'b0 || rdata !== 32'h0 || bus_req !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_late_rvalid done=%b rdata=%h req=%b expected 0 0 0", done, rdata, bus_req); end
        tick();
        vectors++; if (done !== 1'b0 || rdata !== 32'h0) begin
            miscompares++; $display("FAIL mid_reset_settle done=%b rdata=%h expected 0 0", done, rdata); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_sub_word_loads();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
